// File: rtl/ex_muldiv.sv
// -----------------------------------------------------------------------------
// ex_muldiv -- iterative multiply / divide unit with HI/LO architectural regs
//
// Purpose
//   Executes MULT, MULTU, DIV and DIVU over WIDTH iterations: one product bit
//   per cycle for shift-add multiply, one quotient bit per cycle for restoring
//   divide. MTHI and MTLO write HI or LO directly in a single cycle. Signed
//   operations run on operand magnitudes, and the signs are applied when the
//   result is written.
//
// Parameters
//   WIDTH  operand width (even, 8..64), default 32
//   CNT_W  iteration counter width, default $clog2(WIDTH)+1
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous, active-high reset
//   flush       in   aborts an in-flight operation and blocks this cycle's request
//   start       in   operation request, qualified by op
//   op[2:0]     in   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   src_a       in   multiplicand / dividend / MTHI-MTLO data
//   src_b       in   multiplier / divisor
//   stall       out  high in the request cycle of a mul/div and in every RUN cycle
//   done        out  one-cycle pulse in the cycle after HI/LO take a mul/div result
//   hilo_value  out  {HI, LO}
//
// Configuration macro
//   MULDIV_FAST_MUL_EN  when defined, MULT/MULTU finish in a single RUN cycle
//                       using a combinational multiplier. Divide is unchanged.
//
// Handshake: start is a request that is taken only in IDLE with flush=0.
// stall is the hold-back signal to the pipeline. It goes high combinationally
// in the cycle a mul/div request is taken and stays high through RUN. The
// requester must keep the pipeline frozen while stall=1. A start seen while
// stall=1 from RUN is ignored.
// -----------------------------------------------------------------------------
module ex_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     src_a,
  input  logic [WIDTH-1:0]     src_b,
  output logic                 stall,
  output logic                 done,
  output logic [2*WIDTH-1:0]   hilo_value
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  // Architectural and control state
  logic [0:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_done;

  // Per-operation context latched on acceptance
  logic                 r_is_div;
  logic                 r_neg_q;    // negate the product (mul) or the quotient (div)
  logic                 r_neg_r;    // negate the remainder (div only)
  logic                 r_div0;
  logic [WIDTH-1:0]     r_a_orig;   // raw dividend, returned in HI on divide by zero
  logic [WIDTH-1:0]     r_opb;      // |multiplicand| for mul, |divisor| for div

  // Shared datapath accumulator:
  //   mul: {partial product high, multiplier bits still to be consumed}
  //   div: {partial remainder, dividend bits still to be consumed / quotient}
  logic [2*WIDTH-1:0]   r_acc;

  logic                 w_accept;
  logic                 w_req_long;
  logic                 w_last;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic                 w_signed;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;

  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [WIDTH:0]       w_div_shift;
  logic [WIDTH:0]       w_div_diff;
  logic                 w_div_ge;
  logic [2*WIDTH-1:0]   w_div_next;
  logic [2*WIDTH-1:0]   w_mul_final;
  logic [2*WIDTH-1:0]   w_step;
  logic [2*WIDTH-1:0]   w_result;

  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign w_accept   = (r_state == S_IDLE) && start && !flush;
  assign w_req_long = w_accept && !op[2];

  assign w_signed = (op == OP_MULT) || (op == OP_DIV);
  assign w_a_neg  = w_signed && src_a[WIDTH-1];
  assign w_b_neg  = w_signed && src_b[WIDTH-1];
  assign w_a_mag  = f_mag(src_a, w_a_neg);
  assign w_b_mag  = f_mag(src_b, w_b_neg);

  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      stall = (r_state == S_RUN) || w_req_long;
    end
  end

  // ---------------------------------------------------------------------------
  // One shift-add multiply step: add the multiplicand when the next multiplier
  // bit is set, then shift the whole accumulator right with the carry.
  // ---------------------------------------------------------------------------
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                      (r_acc[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // ---------------------------------------------------------------------------
  // One restoring divide step. The partial remainder is always below the divisor,
  // so the shifted value is below twice the divisor. That makes bit WIDTH of the
  // difference a clean borrow flag. With a zero divisor the subtraction always
  // succeeds, which gives an all-ones quotient. That case is overridden below.
  // ---------------------------------------------------------------------------
  assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opb};
  assign w_div_ge    = !w_div_diff[WIDTH];
  assign w_div_next  = w_div_ge ? {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                                : {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

`ifdef MULDIV_FAST_MUL_EN
  // Single-cycle multiplier on the latched magnitudes. The first RUN cycle is
  // the last one for a multiply.
  assign w_mul_final = {{WIDTH{1'b0}}, r_opb} * {{WIDTH{1'b0}}, r_acc[WIDTH-1:0]};
  assign w_last      = r_is_div ? (r_cnt == LAST_CNT) : 1'b1;
`else
  assign w_mul_final = w_mul_next;
  assign w_last      = (r_cnt == LAST_CNT);
`endif

  assign w_step = r_is_div ? w_div_next : w_mul_final;

  // Sign fix-up and special cases, applied only on the writing edge
  always_comb begin
    w_result = w_step;
    if (!r_is_div) begin
      w_result = r_neg_q ? -w_step : w_step;
    end else if (r_div0) begin
      w_result = {r_a_orig, {WIDTH{1'b1}}};
    end else begin
      w_result[2*WIDTH-1:WIDTH] = f_mag(w_step[2*WIDTH-1:WIDTH], r_neg_r);
      w_result[WIDTH-1:0]       = f_mag(w_step[WIDTH-1:0], r_neg_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM and architectural registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_a_orig <= '0;
      r_opb    <= '0;
      r_acc    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (op)
              OP_MTHI: r_hi <= src_a;
              OP_MTLO: r_lo <= src_a;
              OP_MULT, OP_MULTU: begin
                r_state  <= S_RUN;
                r_cnt    <= '0;
                r_is_div <= 1'b0;
                r_neg_q  <= w_a_neg ^ w_b_neg;
                r_neg_r  <= 1'b0;
                r_div0   <= 1'b0;
                r_a_orig <= src_a;
                r_opb    <= w_a_mag;
                r_acc    <= {{WIDTH{1'b0}}, w_b_mag};
              end
              OP_DIV, OP_DIVU: begin
                r_state  <= S_RUN;
                r_cnt    <= '0;
                r_is_div <= 1'b1;
                r_neg_q  <= w_a_neg ^ w_b_neg;
                r_neg_r  <= w_a_neg;
                r_div0   <= (src_b == '0);
                r_a_orig <= src_a;
                r_opb    <= w_b_mag;
                r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
              end
              default: ;  // op 6-7: no-op
            endcase
          end
        end
        S_RUN: begin
          if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (w_last) begin
            r_hi    <= w_result[2*WIDTH-1:WIDTH];
            r_lo    <= w_result[WIDTH-1:0];
            r_done  <= 1'b1;
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_acc <= w_step;
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign done       = r_done;
  assign hilo_value = {r_hi, r_lo};

endmodule

// File: tb/tb_ex_muldiv.sv
// -----------------------------------------------------------------------------
// tb_ex_muldiv -- self-checking bench for ex_muldiv (WIDTH=32)
// Directed vector table, hand-written multi-cycle sequences (flush, reset,
// start-in-RUN, MTHI/MTLO), then randomized operations checked against an
// arithmetic reference model of HI/LO.
// -----------------------------------------------------------------------------
module tb_ex_muldiv;

  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W;
`endif

  logic          clk;
  logic          rst;
  logic          flush;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  src_a;
  logic [W-1:0]  src_b;
  logic          stall;
  logic          done;
  logic [2*W-1:0] hilo_value;

  int n_pass;
  int n_total;

  logic [W-1:0] ref_hi;
  logic [W-1:0] ref_lo;

  typedef struct {
    logic [2:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
    string          name;
  } vec_t;

  vec_t vecs[10];

  ex_muldiv #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .start      (start),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .stall      (stall),
    .done       (done),
    .hilo_value (hilo_value)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checker
  function automatic void chk(input string name, input logic [2*W-1:0] act,
                              input logic [2*W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // ---------------------------------------------------------------- reference model
  function automatic logic [2*W-1:0] model(input logic [2:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      3'd0: return 64'(sa * sb);
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: return {ref_hi, ref_lo};
    endcase
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------------------------------------------------------- driver tasks
  task automatic idle_inputs();
    start = 1'b0;
    flush = 1'b0;
    op    = 3'd6;
  endtask

  // Issue a mul/div and follow it to done. poke >= 0 drives a MTHI request
  // during that RUN cycle, which the block must ignore.
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] exp, input string name, input int poke);
    int lat;
    int stall_low;
    int exp_lat;
    exp_lat = o[1] ? W : MUL_LAT;
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    #1;
    chk({name, "_stall_req"}, 64'(stall), 64'd1);
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    lat = 0;
    stall_low = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (stall !== 1'b1) stall_low++;
      if (lat == poke) begin
        start = 1'b1; op = 3'd4; src_a = 32'hDEAD_BEEF;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
      idle_inputs();
    end
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({name, "_stall_run"}, 64'(stall_low), 64'd0);
    chk({name, "_stall_after"}, 64'(stall), 64'd0);
    chk({name, "_hilo"}, hilo_value, exp);
    @(negedge clk);
    chk({name, "_done_once"}, 64'(done), 64'd0);
    ref_hi = exp[2*W-1:W];
    ref_lo = exp[W-1:0];
  endtask

  task automatic do_move(input logic [2:0] o, input logic [W-1:0] a, input string name);
    @(negedge clk);
    op = o; src_a = a; start = 1'b1;
    #1;
    chk({name, "_stall"}, 64'(stall), 64'd0);
    @(negedge clk);
    idle_inputs();
    if (o == 3'd4) ref_hi = a;
    if (o == 3'd5) ref_lo = a;
    chk({name, "_hilo"}, hilo_value, {ref_hi, ref_lo});
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    logic [2*W-1:0] prior;
    logic           saw_done;
    logic [2:0]     ro;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;

    n_pass = 0;
    n_total = 0;
    ref_hi = '0;
    ref_lo = '0;
    src_a = '0;
    src_b = '0;
    idle_inputs();

    vecs[0] = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, "mult_7_m3"};
    vecs[1] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, "div_m7_2"};
    vecs[2] = '{3'd3, 32'h0000_0064, 32'h0000_0000, 64'h0000_0064_FFFF_FFFF, "divu_by0"};
    vecs[3] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "div_ovf"};
    vecs[4] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "multu_max"};
    vecs[5] = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, "div_7_m2"};
    vecs[6] = '{3'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 64'hFFFF_FFFF_0000_0003, "div_m7_m2"};
    vecs[7] = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0010, 64'h0000_000F_0FFF_FFFF, "divu_max_16"};
    vecs[8] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "mult_min_min"};
    vecs[9] = '{3'd2, 32'hFFFF_FFFB, 32'h0000_0000, 64'hFFFF_FFFB_FFFF_FFFF, "div_neg_by0"};

    // Reset, with a mul request held high to show reset overrides it
    rst = 1'b1;
    start = 1'b1; op = 3'd0; src_a = 32'd9; src_b = 32'd9;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 64'(stall), 64'd0);
    rst = 1'b0;
    idle_inputs();
    chk("rst_hilo", hilo_value, 64'd0);
    chk("rst_done", 64'(done), 64'd0);

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name, -1);
    end

    // MTHI then MTLO on consecutive cycles
    @(negedge clk);
    op = 3'd4; src_a = 32'h1234_5678; start = 1'b1;
    #1 chk("mthi_stall", 64'(stall), 64'd0);
    @(negedge clk);
    op = 3'd5; src_a = 32'h9ABC_DEF0;
    #1 chk("mtlo_stall", 64'(stall), 64'd0);
    @(negedge clk);
    idle_inputs();
    chk("mthi_mtlo_hilo", hilo_value, 64'h1234_5678_9ABC_DEF0);
    ref_hi = 32'h1234_5678;
    ref_lo = 32'h9ABC_DEF0;

    // Flush in IDLE blocks a MTHI and a MULT. Op 6/7 are no-ops.
    @(negedge clk);
    flush = 1'b1; start = 1'b1; op = 3'd4; src_a = 32'hCAFE_F00D;
    @(negedge clk);
    op = 3'd0; src_a = 32'd3; src_b = 32'd3;
    #1 chk("flush_idle_stall", 64'(stall), 64'd0);
    @(negedge clk);
    flush = 1'b0; op = 3'd7;
    #1 chk("nop7_stall", 64'(stall), 64'd0);
    @(negedge clk);
    op = 3'd6;
    @(negedge clk);
    idle_inputs();
    chk("flush_idle_nop_hilo", hilo_value, 64'h1234_5678_9ABC_DEF0);
    chk("flush_idle_done", 64'(done), 64'd0);

    // DIVU flushed at iteration 10
    prior = hilo_value;
    @(negedge clk);
    op = 3'd3; src_a = 32'd1000; src_b = 32'd7; start = 1'b1;
    @(negedge clk);
    idle_inputs();
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_run_stall", 64'(stall), 64'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("flush_run_no_done", 64'(saw_done), 64'd0);
    chk("flush_run_hilo", hilo_value, prior);
    do_op(3'd1, 32'd3, 32'd5, 64'd15, "multu_3x5", -1);

    // Start during RUN is ignored
    do_op(3'd2, 32'hFFFF_FF9C, 32'd7, model(3'd2, 32'hFFFF_FF9C, 32'd7), "div_poke", 4);

    // Reset at iteration 5 of a long op
    @(negedge clk);
    op = (MUL_LAT > 5) ? 3'd0 : 3'd2;
    src_a = 32'd12345; src_b = 32'd678; start = 1'b1;
    @(negedge clk);
    idle_inputs();
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_hilo", hilo_value, 64'd0);
    chk("rst_mid_stall", 64'(stall), 64'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("rst_mid_no_done", 64'(saw_done), 64'd0);
    ref_hi = '0;
    ref_lo = '0;

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 5));
      ra = pick_operand();
      rb = pick_operand();
      if (ro[2]) do_move(ro, ra, $sformatf("rnd%0d_move", i));
      else do_op(ro, ra, rb, model(ro, ra, rb), $sformatf("rnd%0d_op%0d", i, ro), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
